// File: rtl/mem_lsu.sv
// Load/store unit: one memory operation in flight, byte-lane alignment, load sign/zero extension.
// Optional bus watchdog enabled by defining MEM_LSU_WATCHDOG_EN.
module mem_lsu #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int TMO = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [AW-1:0]   in_addr,
    input  logic [DW-1:0]   in_wdata,
    input  logic [36:0]     in_tag,
    output logic            dm_req,
    output logic            dm_we,
    output logic [AW-1:0]   dm_addr,
    output logic [DW/8-1:0] dm_wstrb,
    output logic [DW-1:0]   dm_wdata,
    input  logic            dm_gnt,
    input  logic            dm_rvalid,
    input  logic [DW-1:0]   dm_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [36:0]     out_tag,
    output logic            out_adel,
    output logic            out_ades,
    output logic            out_berr
);

    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state_reg;
    logic [3:0]      op_reg;
    logic [LB-1:0]   lane_reg;

    logic            dec_ld;
    logic            dec_st;
    logic            dec_mis;
    logic [1:0]      dec_sz;
    logic [NB-1:0]   strb_base;
    logic [NB-1:0]   dec_strb;
    logic [DW-1:0]   dec_wdata;
    logic [AW-1:0]   dec_addr;
    logic [DW-1:0]   rd_shift;
    logic [DW-1:0]   ld_data;

    // Access size: 0 byte, 1 halfword, 2 word, 3 doubleword.
    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            4'd3, 4'd4, 4'd7: op_size = 2'd1;
            4'd5, 4'd8:       op_size = 2'd2;
            4'd9, 4'd10:      op_size = 2'd3;
            default:          op_size = 2'd0;
        endcase
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        is_load = (op >= 4'd1 && op <= 4'd5) || (op == 4'd9 && DW == 64);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        is_store = (op >= 4'd6 && op <= 4'd8) || (op == 4'd10 && DW == 64);
    endfunction

    assign in_ready = (state_reg == IDLE);

    always_comb begin
        dec_ld   = is_load(in_op);
        dec_st   = is_store(in_op);
        dec_sz   = op_size(in_op);
        dec_addr = in_addr & ~AW'(NB - 1);
        case (dec_sz)
            2'd0:    dec_mis = 1'b0;
            2'd1:    dec_mis = in_addr[0];
            2'd2:    dec_mis = |in_addr[1:0];
            default: dec_mis = |in_addr[2:0];
        endcase
        case (dec_sz)
            2'd0:    strb_base = NB'(1);
            2'd1:    strb_base = NB'(3);
            2'd2:    strb_base = NB'(15);
            default: strb_base = '1;
        endcase
        dec_strb = strb_base << in_addr[LB-1:0];
        // The store source is replicated so every lane carries it; strobes pick the lane.
        case (dec_sz)
            2'd0:    dec_wdata = {NB{in_wdata[7:0]}};
            2'd1:    dec_wdata = {(NB/2){in_wdata[15:0]}};
            2'd2:    dec_wdata = {(NB/4){in_wdata[31:0]}};
            default: dec_wdata = in_wdata;
        endcase
    end

    always_comb begin
        rd_shift = dm_rdata >> {lane_reg, 3'b000};
        case (op_reg)
            4'd1:    ld_data = DW'($signed(rd_shift[7:0]));
            4'd2:    ld_data = DW'(rd_shift[7:0]);
            4'd3:    ld_data = DW'($signed(rd_shift[15:0]));
            4'd4:    ld_data = DW'(rd_shift[15:0]);
            4'd5:    ld_data = DW'($signed(rd_shift[31:0]));
            default: ld_data = rd_shift;
        endcase
    end

`ifdef MEM_LSU_WATCHDOG_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] wd_cnt_reg;
    logic          wd_expired;
    assign wd_expired = (wd_cnt_reg == CW'(TMO - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TMO > 0);
    assign out_berr   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            lane_reg  <= '0;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wstrb  <= '0;
            dm_wdata  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_adel  <= 1'b0;
            out_ades  <= 1'b0;
`ifdef MEM_LSU_WATCHDOG_EN
            out_berr   <= 1'b0;
            wd_cnt_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_reg   <= in_op;
                        lane_reg <= in_addr[LB-1:0];
                        out_tag  <= in_tag;
                        out_adel <= dec_ld & dec_mis;
                        out_ades <= dec_st & dec_mis;
`ifdef MEM_LSU_WATCHDOG_EN
                        out_berr   <= 1'b0;
                        wd_cnt_reg <= '0;
`endif
                        if ((dec_ld || dec_st) && !dec_mis) begin
                            state_reg <= REQ;
                            dm_req    <= 1'b1;
                            dm_we     <= dec_st;
                            dm_addr   <= dec_addr;
                            dm_wstrb  <= dec_st ? dec_strb : '0;
                            dm_wdata  <= dec_wdata;
                        end else begin
                            // NOP and misaligned ops complete without touching memory.
                            state_reg <= RESP;
                            out_valid <= 1'b1;
                            out_data  <= (dec_ld || dec_st) ? '0 : in_wdata;
                        end
                    end
                end
                REQ: begin
                    if (dm_gnt) begin
                        dm_req   <= 1'b0;
                        dm_we    <= 1'b0;
                        dm_wstrb <= '0;
                        if (dm_we) begin
                            state_reg <= RESP;
                            out_valid <= 1'b1;
                            out_data  <= '0;
                        end else begin
                            state_reg <= WAIT;
`ifdef MEM_LSU_WATCHDOG_EN
                            wd_cnt_reg <= '0;
`endif
                        end
                    end
`ifdef MEM_LSU_WATCHDOG_EN
                    else if (wd_expired) begin
                        dm_req    <= 1'b0;
                        dm_we     <= 1'b0;
                        dm_wstrb  <= '0;
                        state_reg <= RESP;
                        out_valid <= 1'b1;
                        out_data  <= '0;
                        out_berr  <= 1'b1;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + CW'(1);
                    end
`endif
                end
                WAIT: begin
                    if (dm_rvalid) begin
                        state_reg <= RESP;
                        out_valid <= 1'b1;
                        out_data  <= ld_data;
                    end
`ifdef MEM_LSU_WATCHDOG_EN
                    else if (wd_expired) begin
                        state_reg <= RESP;
                        out_valid <= 1'b1;
                        out_data  <= '0;
                        out_berr  <= 1'b1;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + CW'(1);
                    end
`endif
                end
                RESP: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: one DW=32 and one DW=64 instance share stimulus, selected by sel.
module tb_mem_lsu;

    localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4, LW = 4'd5;
    localparam logic [3:0] SB = 4'd6, SH = 4'd7, SW = 4'd8, LD = 4'd9, SD = 4'd10;

    logic        clk;
    logic        resetn;
    logic        sel;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [63:0] in_wdata;
    logic [36:0] in_tag;
    logic        out_ready;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [63:0] dm_rdata;

    logic        ir32, ir64, dreq32, dreq64, dwe32, dwe64;
    logic [31:0] daddr32, daddr64;
    logic [3:0]  dstrb32;
    logic [7:0]  dstrb64;
    logic [31:0] dwd32, od32;
    logic [63:0] dwd64, od64;
    logic        ov32, ov64, adel32, adel64, ades32, ades64, berr32, berr64;
    logic [36:0] ot32, ot64;

    logic        in_ready, m_dm_req, m_dm_we, out_valid, out_adel, out_ades, out_berr;
    logic [31:0] m_dm_addr;
    logic [7:0]  m_dm_wstrb;
    logic [63:0] m_dm_wdata, out_data;
    logic [36:0] out_tag;

    mem_lsu #(.DW(32), .AW(32), .TMO(16)) u_dut32 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid & ~sel), .in_ready(ir32), .in_op(in_op), .in_addr(in_addr),
        .in_wdata(in_wdata[31:0]), .in_tag(in_tag),
        .dm_req(dreq32), .dm_we(dwe32), .dm_addr(daddr32), .dm_wstrb(dstrb32), .dm_wdata(dwd32),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata[31:0]),
        .out_valid(ov32), .out_ready(out_ready), .out_data(od32), .out_tag(ot32),
        .out_adel(adel32), .out_ades(ades32), .out_berr(berr32)
    );

    mem_lsu #(.DW(64), .AW(32), .TMO(16)) u_dut64 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid & sel), .in_ready(ir64), .in_op(in_op), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_tag(in_tag),
        .dm_req(dreq64), .dm_we(dwe64), .dm_addr(daddr64), .dm_wstrb(dstrb64), .dm_wdata(dwd64),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .out_valid(ov64), .out_ready(out_ready), .out_data(od64), .out_tag(ot64),
        .out_adel(adel64), .out_ades(ades64), .out_berr(berr64)
    );

    assign in_ready   = sel ? ir64 : ir32;
    assign m_dm_req   = sel ? dreq64 : dreq32;
    assign m_dm_we    = sel ? dwe64 : dwe32;
    assign m_dm_addr  = sel ? daddr64 : daddr32;
    assign m_dm_wstrb = sel ? dstrb64 : {4'b0, dstrb32};
    assign m_dm_wdata = sel ? dwd64 : {32'b0, dwd32};
    assign out_valid  = sel ? ov64 : ov32;
    assign out_data   = sel ? od64 : {32'b0, od32};
    assign out_tag    = sel ? ot64 : ot32;
    assign out_adel   = sel ? adel64 : adel32;
    assign out_ades   = sel ? ades64 : ades32;
    assign out_berr   = sel ? berr64 : berr32;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [36:0] tag;
        logic        adel;
        logic        ades;
        logic        berr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic        we;
    } req_t;

    exp_t sb_q[$];
    req_t req_q[$];

    int checks = 0;
    int failures = 0;
    int grants = 0;
    int gnt_cnt = 0;
    int n_ops = 0;
    bit hold_gnt = 1'b0;
    bit hold_rv = 1'b0;
    bit pend_rv = 1'b0;
    bit force_rv = 1'b0;
    logic [63:0] mem_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Result monitor: compares every output handshake against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got data 0x%0h expected no result", out_data);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                chk("out_adel", 64'(out_adel), 64'(e.adel));
                chk("out_ades", 64'(out_ades), 64'(e.ades));
                chk("out_berr", 64'(out_berr), 64'(e.berr));
                $display("result: data=0x%0h tag=0x%0h adel=%0b ades=%0b berr=%0b",
                         out_data, out_tag, out_adel, out_ades, out_berr);
            end
        end
    end

    // Memory responder: checks each presented request and grants after gnt_cnt idle cycles.
    initial begin
        dm_gnt = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata = '0;
        forever begin
            @(negedge clk);
            dm_gnt = 1'b0;
            dm_rvalid = 1'b0;
            if (pend_rv && !hold_rv) begin
                dm_rvalid = 1'b1;
                dm_rdata = mem_rdata;
                pend_rv = 1'b0;
            end
            if (force_rv) begin
                dm_rvalid = 1'b1;
                force_rv = 1'b0;
            end
            if (resetn && m_dm_req) begin
                if (req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got addr 0x%0h expected no request", m_dm_addr);
                end else begin
                    chk("dm_addr", 64'(m_dm_addr), 64'(req_q[0].addr));
                    chk("dm_we", 64'(m_dm_we), 64'(req_q[0].we));
                    chk("dm_wstrb", 64'(m_dm_wstrb), 64'(req_q[0].strb));
                    if (req_q[0].we) chk("dm_wdata", m_dm_wdata, req_q[0].wdata);
                    if (!hold_gnt) begin
                        if (gnt_cnt == 0) begin
                            dm_gnt = 1'b1;
                            grants++;
                            if (!m_dm_we) pend_rv = 1'b1;
                            void'(req_q.pop_front());
                        end else begin
                            gnt_cnt--;
                        end
                    end
                end
            end
        end
    end

    task automatic do_op(input bit s, input logic [3:0] op, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input int gwait, input int hold, input int exp_lat,
                         input logic [63:0] exp_data, input bit adel, input bit ades, input bit berr,
                         input bit has_req, input logic [31:0] r_addr, input logic [7:0] r_strb,
                         input logic [63:0] r_wdata, input bit r_we);
        int lat;
        int g0;
        logic [36:0] tag;
        @(posedge clk);
        #1;
        tag = {n_ops[4:0], 32'h4000_0000 + 32'(n_ops * 4)};
        n_ops++;
        sel = s;
        sb_q.push_back('{exp_data, tag, adel, ades, berr});
        if (has_req) req_q.push_back('{r_addr, r_strb, r_wdata, r_we});
        mem_rdata = rdata;
        gnt_cnt = gwait;
        g0 = grants;
        in_valid = 1'b1;
        in_op = op;
        in_addr = addr;
        in_wdata = wdata;
        in_tag = tag;
        out_ready = (hold == 0);
        $display("op: dw=%0d op=%0d addr=0x%0h wdata=0x%0h", s ? 64 : 32, op, addr, wdata);
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("resp_dm_req", 64'(m_dm_req), 64'd0);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, exp_data);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            if (i == hold - 1) out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_in_ready", 64'(in_ready), 64'd1);
        chk("post_valid", 64'(out_valid), 64'd0);
        chk("grants", 64'(grants - g0), 64'(has_req && !hold_gnt));
    endtask

    initial begin
        int g0;
        resetn = 1'b0;
        sel = 1'b0;
        in_valid = 1'b0;
        in_op = '0;
        in_addr = '0;
        in_wdata = '0;
        in_tag = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            sel = s[0];
            #1;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_dm_req", 64'(m_dm_req), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_data", out_data, 64'd0);
            chk("rst_out_tag", 64'(out_tag), 64'd0);
            chk("rst_flags", 64'({out_adel, out_ades, out_berr}), 64'd0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // DW=32 instance
        do_op(0, NOP, 32'h0,   64'h1234_5678, 64'h0,          0, 0, 1, 64'h1234_5678, 0, 0, 0, 0, 32'h0,   8'h0, 64'h0, 0);
        do_op(0, LB,  32'h103, 64'h0,         64'h80FF_FF7F,  0, 0, 3, 64'hFFFF_FF80, 0, 0, 0, 1, 32'h100, 8'h0, 64'h0, 0);
        do_op(0, LBU, 32'h101, 64'h0,         64'h80FF_FF7F,  0, 0, 3, 64'h0000_00FF, 0, 0, 0, 1, 32'h100, 8'h0, 64'h0, 0);
        do_op(0, LH,  32'h102, 64'h0,         64'h80FF_FF7F,  0, 0, 3, 64'hFFFF_80FF, 0, 0, 0, 1, 32'h100, 8'h0, 64'h0, 0);
        do_op(0, LHU, 32'h100, 64'h0,         64'h80FF_FF7F,  0, 0, 3, 64'h0000_FF7F, 0, 0, 0, 1, 32'h100, 8'h0, 64'h0, 0);
        do_op(0, LW,  32'h104, 64'h0,         64'hDEAD_BEEF,  2, 3, 5, 64'hDEAD_BEEF, 0, 0, 0, 1, 32'h104, 8'h0, 64'h0, 0);
        do_op(0, SB,  32'h203, 64'h0000_00A5, 64'h0,          0, 0, 2, 64'h0,         0, 0, 0, 1, 32'h200, 8'h8, 64'hA5A5_A5A5, 1);
        do_op(0, SH,  32'h202, 64'h0000_BEEF, 64'h0,          0, 0, 2, 64'h0,         0, 0, 0, 1, 32'h200, 8'hC, 64'hBEEF_BEEF, 1);
        do_op(0, SW,  32'h208, 64'hCAFE_F00D, 64'h0,          1, 0, 3, 64'h0,         0, 0, 0, 1, 32'h208, 8'hF, 64'hCAFE_F00D, 1);
        do_op(0, LW,  32'h105, 64'h0,         64'h0,          0, 0, 1, 64'h0,         1, 0, 0, 0, 32'h0,   8'h0, 64'h0, 0);
        do_op(0, SH,  32'h201, 64'h1111,      64'h0,          0, 0, 1, 64'h0,         0, 1, 0, 0, 32'h0,   8'h0, 64'h0, 0);
        do_op(0, LH,  32'h103, 64'h0,         64'h0,          0, 0, 1, 64'h0,         1, 0, 0, 0, 32'h0,   8'h0, 64'h0, 0);
        do_op(0, LD,  32'h18,  64'h0BAD_F00D, 64'h0,          0, 0, 1, 64'h0BAD_F00D, 0, 0, 0, 0, 32'h0,   8'h0, 64'h0, 0);
        do_op(0, SD,  32'h20,  64'h77,        64'h0,          0, 0, 1, 64'h77,        0, 0, 0, 0, 32'h0,   8'h0, 64'h0, 0);
        do_op(0, 4'd15, 32'h0, 64'h5A5A,      64'h0,          0, 0, 1, 64'h5A5A,      0, 0, 0, 0, 32'h0,   8'h0, 64'h0, 0);

        // DW=64 instance
        do_op(1, LD,  32'h18,  64'h0, 64'h0123_4567_89AB_CDEF, 0, 3, 3, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 1, 32'h18, 8'h00, 64'h0, 0);
        do_op(1, SD,  32'h20,  64'h1122_3344_5566_7788, 64'h0, 0, 0, 2, 64'h0, 0, 0, 0, 1, 32'h20, 8'hFF, 64'h1122_3344_5566_7788, 1);
        do_op(1, SW,  32'h24,  64'hCAFE_F00D, 64'h0,           0, 0, 2, 64'h0, 0, 0, 0, 1, 32'h20, 8'hF0, 64'hCAFE_F00D_CAFE_F00D, 1);
        do_op(1, SH,  32'h26,  64'h1234, 64'h0,                0, 0, 2, 64'h0, 0, 0, 0, 1, 32'h20, 8'hC0, 64'h1234_1234_1234_1234, 1);
        do_op(1, LW,  32'h1C,  64'h0, 64'h8000_0001_1234_5678, 0, 0, 3, 64'hFFFF_FFFF_8000_0001, 0, 0, 0, 1, 32'h18, 8'h00, 64'h0, 0);
        do_op(1, LB,  32'h1F,  64'h0, 64'h7F00_0000_0000_0000, 0, 0, 3, 64'h7F, 0, 0, 0, 1, 32'h18, 8'h00, 64'h0, 0);
        do_op(1, LHU, 32'h1A,  64'h0, 64'h0000_0000_BEEF_0000, 0, 0, 3, 64'hBEEF, 0, 0, 0, 1, 32'h18, 8'h00, 64'h0, 0);
        do_op(1, LD,  32'h1C,  64'h0, 64'h0,                   0, 0, 1, 64'h0, 1, 0, 0, 0, 32'h0, 8'h0, 64'h0, 0);
        do_op(1, SD,  32'h22,  64'h0, 64'h0,                   0, 0, 1, 64'h0, 0, 1, 0, 0, 32'h0, 8'h0, 64'h0, 0);

        // Reset while a load waits for data; the late rvalid must be ignored.
        @(posedge clk);
        #1;
        sel = 1'b0;
        hold_rv = 1'b1;
        req_q.push_back('{32'h100, 8'h0, 64'h0, 1'b0});
        gnt_cnt = 0;
        g0 = grants;
        in_valid = 1'b1;
        in_op = LW;
        in_addr = 32'h100;
        in_tag = 37'h1F_DEAD_0000;
        $display("op: reset during WAIT, LW addr=0x100");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        pend_rv = 1'b0;
        hold_rv = 1'b0;
        force_rv = 1'b1;
        @(negedge clk);
        chk("rstw_grants", 64'(grants - g0), 64'd1);
        chk("rstw_out_data", out_data, 64'd0);
        chk("rstw_out_tag", 64'(out_tag), 64'd0);
        chk("rstw_dm_req", 64'(m_dm_req), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rstw_out_valid", 64'(out_valid), 64'd0);
            chk("rstw_in_ready", 64'(in_ready), 64'd1);
            @(negedge clk);
        end

`ifdef MEM_LSU_WATCHDOG_EN
        hold_gnt = 1'b1;
        do_op(0, LW, 32'h300, 64'h0, 64'h0, 0, 0, 17, 64'h0, 0, 0, 1, 1, 32'h300, 8'h0, 64'h0, 0);
        hold_gnt = 1'b0;
        void'(req_q.pop_front());
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("req_q_empty", 64'(req_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DW, 32, data path width; legal values 32 or 64.
REQ-002 Parameter AW, 32, address width.
REQ-003 Parameter TMO, 16, watchdog limit in cycles; used only when MEM_LSU_WATCHDOG_EN is defined.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  upstream presents an operation.
REQ-007 in_ready  output  1  block accepts an operation this cycle.
REQ-008 in_op  input  4  0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LD, 10 SD; 9/10 legal only when DW=64, otherwise NOP.
REQ-009 in_addr  input  AW  effective address.
REQ-010 in_wdata  input  DW  store source / pass-through result.
REQ-011 in_tag  input  37  {rf_wdest[4:0], pc[31:0]}, carried unchanged to output.
REQ-012 dm_req, dm_we  output  1 each  memory request and write flag.
REQ-013 dm_addr  output  AW  request address, aligned down to DW/8 bytes.
REQ-014 dm_wstrb  output  DW/8  byte write strobes.
REQ-015 dm_wdata  output  DW  write data, source replicated into every lane.
REQ-016 dm_gnt  input  1  memory accepts request.
REQ-017 dm_rvalid  input  1  read data valid.
REQ-018 dm_rdata  input  DW  read data.
REQ-019 out_valid  output  1  result available.
REQ-020 out_ready  input  1  downstream takes result.
REQ-021 out_data, out_tag  output  DW, 37  result and carried tag.
REQ-022 out_adel, out_ades, out_berr  output  1 each  load-misaligned, store-misaligned, bus timeout.

Function
REQ-023 States IDLE, REQ, WAIT, RESP.
REQ-024 in_ready = 1 only in IDLE; accept = in_valid & in_ready; in_op, in_addr, in_wdata, in_tag latch on accept.
REQ-025 Alignment: halfword requires addr[0]=0, word addr[1:0]=0, doubleword addr[2:0]=0; byte always aligned.
REQ-026 On accept of NOP or misaligned op: go RESP, no dm_req; out_adel set for misaligned load, out_ades for misaligned store; out_data = latched in_wdata for NOP, 0 otherwise.
REQ-027 On accept of aligned load/store: go REQ; dm_req = 1 whilst in REQ, with dm_addr, dm_we, dm_wstrb, dm_wdata held stable until dm_gnt.
REQ-028 REQ with dm_gnt: store goes RESP (out_data = 0); load goes WAIT.
REQ-029 WAIT with dm_rvalid: register extracted load data and go RESP; dm_rvalid outside WAIT is ignored.
REQ-030 Load extraction selects the lane by addr[log2(DW/8)-1:0]; LB/LH/LW sign-extend, LBU/LHU zero-extend, all to DW.
REQ-031 dm_wstrb: SB 1 bit, SH 2 bits, SW 4 bits, SD all bits, at the addressed lane; 0 when dm_we = 0.
REQ-032 RESP: out_valid = 1; outputs held stable until out_ready; out_ready takes the block to IDLE.
REQ-033 Minimum latency: NOP/exception accepted cycle N gives out_valid in N+1; store with immediate gnt gives N+2; load with rvalid one cycle after gnt gives N+3.
REQ-034 Throughput: at most one operation in flight; next accept in the cycle after the RESP handshake.

Reset
REQ-035 resetn low at a clock edge: state IDLE; dm_req, out_valid, out_adel, out_ades, out_berr = 0; out_data, out_tag = 0; any in-flight operation is discarded.
REQ-036 A dm_rvalid or dm_gnt arriving after reset for a discarded request is ignored.

Configuration
REQ-037 Macro MEM_LSU_WATCHDOG_EN defined: a counter clears on entry to REQ or WAIT and increments each cycle spent in REQ or WAIT; reaching TMO goes RESP with out_berr = 1, out_data = 0, and drops dm_req.
REQ-038 Macro MEM_LSU_WATCHDOG_EN not defined: no counter; out_berr is tied to 0; REQ and WAIT wait indefinitely.

Verification
REQ-039 DW=32, LB at addr 0x103, dm_rdata=0x80FF_FF7F -> out_data=0xFFFF_FF80, out_valid three cycles after accept.
REQ-040 DW=32, SH at 0x202, wdata=0x0000_BEEF -> dm_addr=0x200, dm_wstrb=4'b1100, dm_wdata=0xBEEF_BEEF, dm_we=1.
REQ-041 LW at 0x105 -> out_adel=1, dm_req never asserted, out_valid one cycle after accept.
REQ-042 DW=64, LD at 0x18, dm_rdata=0x0123_4567_89AB_CDEF, out_ready held 0 for 3 cycles -> out_data stable, in_ready=0 until the handshake.
REQ-043 Load in WAIT, resetn pulsed low for one cycle, then dm_rvalid -> out_valid stays 0, state IDLE.
REQ-044 MEM_LSU_WATCHDOG_EN defined, TMO=16, dm_gnt never asserted -> out_berr=1 and dm_req=0 after 16 cycles in REQ.
